gate_response_monitor: RTL and testbench
========================================

# gate_response_monitor

Synthesizable response checker for 2-input logic-gate DUTs: the observing end of the gate stimulus flow. It watches the DUT inputs `a`, `b` and its output `out`, waits for inputs to settle, compares `out` against a parameterised truth table, and accumulates check, error and coverage results. It sits beside a gate DUT on the FPGA, so gate tests run in hardware without a simulator; `done`/`pass` drive board LEDs or a status register.

## Interface
- `TRUTH_TABLE`, default 4'b1000: expected `out` indexed by `{a,b}`; the default is AND.
- `SETTLE_CYCLES`, default 4: stable cycles required before sampling; must be ≥1.
- `CNT_W`, default 8: width of the check and error counters.

- `clk_50M`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; clears results and arms the monitor.
- `a`  in  1  DUT input a, observed.
- `b`  in  1  DUT input b, observed.
- `out`  in  1  DUT output, observed.
- `busy`  out  1  high in SETTLE, SAMPLE and HOLD.
- `mismatch`  out  1  one-cycle pulse per failed comparison.
- `check_count`  out  CNT_W  number of comparisons made; saturates at all-ones.
- `err_count`  out  CNT_W  number of failed comparisons; saturates at all-ones.
- `coverage`  out  4  bit `{a,b}` set once that combination has been sampled.
- `done`  out  1  high when all four combinations have been covered.
- `pass`  out  1  `done && err_count==0`.

## Operation
**Input stage**
- `a`, `b` and `out` are registered once; all logic uses the registered copies (`ar`, `br`, `outr`).

**States:** IDLE, SETTLE, SAMPLE, HOLD, DONE.
- **IDLE:** outputs hold. `start` clears counters and coverage, loads `prev_ab={ar,br}`, zeroes `settle_cnt`, then goes to SETTLE.
- **SETTLE:**
  - If `{ar,br}!=prev_ab`: `prev_ab` updates and `settle_cnt` returns to 0.
  - Otherwise `settle_cnt` increments.
  - At `settle_cnt==SETTLE_CYCLES-1` with inputs unchanged: go to SAMPLE.
- **SAMPLE** (exactly one cycle):
  - Compare `outr` with `TRUTH_TABLE[{ar,br}]`.
  - `check_count` +1.
  - On mismatch: `err_count` +1 and `mismatch` pulses.
  - Set `coverage[{ar,br}]`.
  - If the updated coverage is 4'b1111, go to DONE; otherwise go to HOLD.
- **HOLD:** wait for `{ar,br}!=prev_ab`, then go to SETTLE with `prev_ab` updated and `settle_cnt` zeroed. Each stable input period is sampled exactly once; revisiting a combination samples it again.
- **DONE:** `done=1`; counters are frozen. Only `start` (re-arm, same as from IDLE) or `reset` leaves DONE.
- **`start` in SETTLE/HOLD/SAMPLE:** restart as from IDLE. `start` has priority over the SAMPLE update in the same cycle.
- **Counters:** both saturate and never wrap; `err_count ≤ check_count` always.
- **`out` during settle:** glitches on `out` while settling are ignored; only `outr` in SAMPLE matters.

## Timing
**Reset** (applies on the first clock edge with `reset=1`, including mid-operation):
- State goes to IDLE.
- `busy`, `mismatch`, `done` and `pass` are 0.
- Counters are 0 and `coverage` is 4'b0000.
- Input registers are 0.

**Sample latency**
- Pins are stable from edge E0, with the monitor in SETTLE or HOLD.
- SAMPLE occupies the cycle after edge E0+SETTLE_CYCLES+1.
- `mismatch` and the counter, coverage and `done` updates are visible after edge E0+SETTLE_CYCLES+2.

**Short pulses and outputs**
- An input change that lasts fewer than SETTLE_CYCLES+1 cycles is never sampled.
- `mismatch` is high for exactly one cycle.
- `pass` is combinational from `done` and `err_count`.

## Structure
- Package `gate_check_pkg`:
  - state enum;
  - truth-table constants `TT_AND=4'b1000`, `TT_OR=4'b1110`, `TT_XOR=4'b0110`, `TT_NAND=4'b0111`.
- Sub-module `gate_stable_detect`: registers `{a,b}` and holds `prev_ab` and `settle_cnt`. It outputs `stable` (one-cycle pulse after SETTLE_CYCLES stable cycles) and `changed`. The top-level FSM and counters consume these signals.

## Test plan
1. **Correct AND DUT.** `start`, then {0,0},{0,1},{1,0},{1,1}, each held 10 cycles with a correct AND output.
   - `check_count=4`, `err_count=0`, `coverage=4'b1111`, `done=1`, `pass=1`.
   - `mismatch` never asserts.
2. **Stuck-at-0 DUT.** Same sequence with `out` stuck at 0.
   - One `mismatch` pulse, at SETTLE_CYCLES+2 edges after {1,1} is applied.
   - `err_count=1`, `done=1`, `pass=0`.
3. **Short glitch.** From {0,0}, drive {1,1} for 2 cycles (SETTLE_CYCLES=4), then return to {0,0}.
   - `coverage[3]` stays 0 and `check_count` does not increment for the glitch.
4. **Revisit a combination.** Sequence {0,0},{0,1},{0,0}.
   - `check_count=3`, `coverage=4'b0011`, `done=0`.
5. **Restart mid-run.** Assert `start` during HOLD after 2 checks.
   - Next cycle: `check_count=0`, `coverage=0`, `busy=1`.
6. **Reset and saturation.**
   - `reset` while in DONE: all outputs 0 and state IDLE on the next edge.
   - With `CNT_W=2` and a faulty DUT toggling {0,0}/{1,1} six times: `err_count` and `check_count` hold at 3.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and truth tables for the gate response monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gate_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  // Expected gate output for one input combination; bit index is {a,b}.
  function automatic logic tt_lookup(input logic [3:0] tt, input logic [1:0] ab);
    return tt[ab];
  endfunction

endpackage

// File: rtl/gate_stable_detect.sv
// Registers the observed gate inputs and measures how long they have been stable.
// Latency: 1 cycle input register; stable fires SETTLE_CYCLES cycles after the change is seen.
// Backpressure: none, observe-only; it never stalls the DUT.
module gate_stable_detect #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       a,
  input  logic       b,
  input  logic       load,
  input  logic       track,
  input  logic       count_en,
  output logic [1:0] ab_r,
  output logic       changed,
  output logic       stable
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  logic [1:0]    prev_ab;
  logic [CW-1:0] settle_cnt;

  assign changed = (ab_r != prev_ab);
  assign stable  = count_en && !changed && (settle_cnt == CW'(SETTLE_CYCLES - 1));

  // Single register stage on the observed pins; everything downstream uses this copy.
  always_ff @(posedge clk_50M) begin
    if (reset) ab_r <= 2'b00;
    else       ab_r <= {a, b};
  end

  // Reference value and stability count; a change always restarts the count.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      prev_ab    <= 2'b00;
      settle_cnt <= '0;
    end else if (load) begin
      prev_ab    <= ab_r;
      settle_cnt <= '0;
    end else if (track && changed) begin
      prev_ab    <= ab_r;
      settle_cnt <= '0;
    end else if (count_en && !stable) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gate_response_monitor.sv
// Checks a 2-input gate DUT output against a truth table once per stable input period.
// Latency: results visible SETTLE_CYCLES+2 edges after the pins settle.
// Backpressure: none, observe-only; counters saturate instead of wrapping.
module gate_response_monitor
  import gate_check_pkg::*;
#(
  parameter logic [3:0] TRUTH_TABLE   = TT_AND,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         CNT_W         = 8
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  input  logic             out,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       coverage,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t     state, state_nxt;
  logic       outr;
  logic [1:0] ab_r;
  logic       changed, stable;
  logic       track, count_en;
  logic       sample_fire, miscmp;
  logic [3:0] cov_nxt;

  assign track       = (state == ST_SETTLE) || (state == ST_HOLD);
  assign count_en    = (state == ST_SETTLE);
  assign sample_fire = (state == ST_SAMPLE) && !start;
  assign miscmp      = sample_fire && (outr != tt_lookup(TRUTH_TABLE, ab_r));
  assign cov_nxt     = coverage | (4'b0001 << ab_r);
  assign pass        = done && (err_count == '0);

  gate_stable_detect #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_stable (
    .clk_50M (clk_50M),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .load    (start),
    .track   (track),
    .count_en(count_en),
    .ab_r    (ab_r),
    .changed (changed),
    .stable  (stable)
  );

  // DUT output is registered alongside the inputs so the comparison sees aligned copies.
  always_ff @(posedge clk_50M) begin
    if (reset) outr <= 1'b0;
    else       outr <= out;
  end

  // State register.
  always_ff @(posedge clk_50M) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and status flags; start re-arms from any state and wins over a sample.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_SETTLE: busy = 1'b1;
      ST_SAMPLE: busy = 1'b1;
      ST_HOLD:   busy = 1'b1;
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
    if (start) begin
      state_nxt = ST_SETTLE;
    end else begin
      case (state)
        ST_SETTLE: if (stable) state_nxt = ST_SAMPLE;
        ST_SAMPLE: state_nxt = (cov_nxt == 4'b1111) ? ST_DONE : ST_HOLD;
        ST_HOLD:   if (changed) state_nxt = ST_SETTLE;
        default:   ;
      endcase
    end
  end

  // Result accumulation: one update per SAMPLE cycle, saturating counters.
  always_ff @(posedge clk_50M) begin
    if (reset || start) begin
      mismatch    <= 1'b0;
      check_count <= '0;
      err_count   <= '0;
      coverage    <= 4'b0000;
    end else begin
      mismatch <= miscmp;
      if (sample_fire) begin
        coverage <= cov_nxt;
        if (check_count != CNT_MAX) check_count <= check_count + 1'b1;
        if (miscmp && (err_count != CNT_MAX)) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gate_response_monitor.sv
// Randomized and directed bench for gate_response_monitor against a segment-level model.
// Latency: model predicts results SETTLE+2 edges after a stable segment begins.
// Backpressure: n/a.
module tb_gate_response_monitor;

  localparam int         S      = 4;
  localparam logic [3:0] AND_TT = 4'b1000;

  logic clk_50M = 1'b0;
  logic reset   = 1'b1;
  logic start   = 1'b0;
  logic a       = 1'b0;
  logic b       = 1'b0;
  logic out     = 1'b0;

  logic       busy8, mism8, done8, pass8;
  logic [7:0] chk8, err8;
  logic [3:0] cov8;
  logic       busy2, mism2, done2, pass2;
  logic [1:0] chk2, err2;
  logic [3:0] cov2;

  gate_response_monitor #(.SETTLE_CYCLES(S), .CNT_W(8)) u_mon (
    .clk_50M(clk_50M), .reset(reset), .start(start), .a(a), .b(b), .out(out),
    .busy(busy8), .mismatch(mism8), .check_count(chk8), .err_count(err8),
    .coverage(cov8), .done(done8), .pass(pass8)
  );

  gate_response_monitor #(.SETTLE_CYCLES(S), .CNT_W(2)) u_sat (
    .clk_50M(clk_50M), .reset(reset), .start(start), .a(a), .b(b), .out(out),
    .busy(busy2), .mismatch(mism2), .check_count(chk2), .err_count(err2),
    .coverage(cov2), .done(done2), .pass(pass2)
  );

  always #10 clk_50M = ~clk_50M;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state: what the monitor should report, in terms of stable input segments.
  int         m_chk = 0;
  int         m_err = 0;
  logic [3:0] m_cov = 4'b0000;
  bit         m_armed = 0;
  bit         m_done  = 0;
  bit         m_mism  = 0;
  logic [1:0] last_ab = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic good(input logic [1:0] ab);
    logic [3:0] tt;
    tt = AND_TT;
    return tt[ab];
  endfunction

  task automatic check_all();
    check_eq("check_count", 32'(chk8), 32'(sat(m_chk, 255)));
    check_eq("err_count",   32'(err8), 32'(sat(m_err, 255)));
    check_eq("coverage",    32'(cov8), 32'(m_cov));
    check_eq("done",        32'(done8), 32'(m_done));
    check_eq("pass",        32'(pass8), 32'(m_done && m_err == 0));
    check_eq("busy",        32'(busy8), 32'(m_armed && !m_done));
    check_eq("mismatch",    32'(mism8), 32'(m_mism));
    check_eq("sat_check",   32'(chk2), 32'(sat(m_chk, 3)));
    check_eq("sat_err",     32'(err2), 32'(sat(m_err, 3)));
    check_eq("sat_cov",     32'(cov2), 32'(m_cov));
    check_eq("sat_done",    32'(done2), 32'(m_done));
    check_eq("sat_pass",    32'(pass2), 32'(m_done && m_err == 0));
    check_eq("sat_busy",    32'(busy2), 32'(m_armed && !m_done));
    check_eq("sat_mismatch",32'(mism2), 32'(m_mism));
  endtask

  // Hold pins {ab} for len edges. out glitches randomly early on, then settles to ov.
  // A segment long enough is checked once; the result shows S+2 edges after it begins,
  // or one edge sooner when start re-arms on pins that did not change.
  task automatic run_seg(input logic [1:0] ab, input logic ov, input int len, input bit st);
    int d, upd;
    bit smp;
    smp = 0;
    d   = (st && ab == last_ab) ? 1 : 0;
    upd = S + 3 - d;
    a = ab[1];
    b = ab[0];
    for (int k = 1; k <= len; k++) begin
      out   = (k < S) ? 1'($urandom_range(0, 1)) : ov;
      start = (k == 1) ? st : 1'b0;
      @(posedge clk_50M);
      m_mism = 0;
      if (k == 1 && st) begin
        m_chk = 0; m_err = 0; m_cov = 4'b0000; m_armed = 1; m_done = 0;
      end
      if (k == 1) smp = m_armed && !m_done && (len >= upd);
      if (smp && k == upd) begin
        m_chk++;
        if (ov != good(ab)) begin
          m_err++;
          m_mism = 1;
        end
        m_cov[ab] = 1'b1;
        m_done = (m_cov == 4'b1111);
      end
      @(negedge clk_50M);
      check_all();
    end
    start   = 1'b0;
    last_ab = ab;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk_50M);
    m_chk = 0; m_err = 0; m_cov = 4'b0000; m_armed = 0; m_done = 0; m_mism = 0;
    @(negedge clk_50M);
    check_all();
    reset = 1'b0;
    @(posedge clk_50M);
    @(negedge clk_50M);
    check_all();
  endtask

  initial begin
    logic [1:0] ab;
    logic       ov;
    int         r;

    do_reset();

    // Correct AND DUT over all four combinations.
    run_seg(2'd0, 1'b0, 10, 1);
    run_seg(2'd1, 1'b0, 10, 0);
    run_seg(2'd2, 1'b0, 10, 0);
    run_seg(2'd3, 1'b1, 10, 0);
    check_eq("and_checks", 32'(chk8), 32'd4);
    check_eq("and_pass",   32'(pass8), 32'd1);

    // Stuck-at-0 DUT: only {1,1} miscompares.
    run_seg(2'd0, 1'b0, 10, 1);
    run_seg(2'd1, 1'b0, 10, 0);
    run_seg(2'd2, 1'b0, 10, 0);
    run_seg(2'd3, 1'b0, 10, 0);
    check_eq("sa0_err",  32'(err8), 32'd1);
    check_eq("sa0_pass", 32'(pass8), 32'd0);

    // Short glitch to {1,1} is never sampled.
    run_seg(2'd0, 1'b0, 10, 1);
    run_seg(2'd3, 1'b1, 2, 0);
    run_seg(2'd0, 1'b0, 10, 0);
    check_eq("glitch_cov3",   32'(cov8[3]), 32'd0);
    check_eq("glitch_checks", 32'(chk8), 32'd2);

    // Revisiting a combination samples it again.
    run_seg(2'd0, 1'b0, 10, 1);
    run_seg(2'd1, 1'b0, 10, 0);
    run_seg(2'd0, 1'b0, 10, 0);
    check_eq("revisit_checks", 32'(chk8), 32'd3);
    check_eq("revisit_cov",    32'(cov8), 32'h3);
    check_eq("revisit_done",   32'(done8), 32'd0);

    // Restart while holding after two checks.
    run_seg(2'd1, 1'b0, 10, 1);
    run_seg(2'd3, 1'b1, 10, 0);
    run_seg(2'd3, 1'b1, 1, 1);
    check_eq("restart_checks", 32'(chk8), 32'd0);
    check_eq("restart_cov",    32'(cov8), 32'd0);
    check_eq("restart_busy",   32'(busy8), 32'd1);
    run_seg(2'd2, 1'b0, 10, 0);

    // Reach DONE, then reset out of it.
    run_seg(2'd0, 1'b0, 10, 1);
    run_seg(2'd1, 1'b0, 10, 0);
    run_seg(2'd2, 1'b0, 10, 0);
    run_seg(2'd3, 1'b1, 10, 0);
    check_eq("pre_reset_done", 32'(done8), 32'd1);
    do_reset();
    check_eq("post_reset_done", 32'(done8), 32'd0);

    // Faulty DUT toggling {0,0}/{1,1}: narrow counters pin at all-ones.
    for (int i = 0; i < 6; i++) begin
      ab = (i % 2 == 0) ? 2'd0 : 2'd3;
      run_seg(ab, ~good(ab), 8, (i == 0));
    end
    check_eq("sat_hold_check", 32'(chk2), 32'd3);
    check_eq("sat_hold_err",   32'(err2), 32'd3);
    check_eq("wide_check",     32'(chk8), 32'd6);

    // Random segments: glitches, stable periods, occasional re-arm or reset.
    run_seg(2'($urandom_range(0, 3)), 1'b0, S + 6, 1);
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 39));
      if (r == 0) begin
        do_reset();
      end else begin
        if (r < 6) ab = 2'($urandom_range(0, 3));
        else       ab = last_ab ^ 2'($urandom_range(1, 3));
        ov = ($urandom_range(0, 3) == 0) ? ~good(ab) : good(ab);
        if (r < 6)       run_seg(ab, ov, int'($urandom_range(S + 3, S + 10)), 1);
        else if (r < 14) run_seg(ab, ov, int'($urandom_range(1, S)), 0);
        else             run_seg(ab, ov, int'($urandom_range(S + 3, S + 10)), 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
